pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameters SHALL be: XLEN, default 32, datapath width; RAW, default 5, register-address width; FLUSH_CYCLES, default 1, bubble cycles per taken branch (range 1-3); CNT_W, default 16, performance-counter width.
REQ-002 Ports SHALL be, in this order:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- id_rs1, id_rs2  in  RAW  ID-stage source registers.
- id_use_rs1, id_use_rs2  in  1  ID source valid.
- id_mc_start  in  1  ID holds a multi-cycle op.
- ex_rs1, ex_rs2  in  RAW  EX-stage source registers.
- ex_rd  in  RAW  EX-stage destination register.
- ex_reg_write, ex_mem_read  in  1  EX-stage control.
- ex_rd1, ex_rd2  in  XLEN  ID/EX operand values.
- ex_branch_taken  in  1  branch resolved taken in EX.
- mem_rd  in  RAW  MEM-stage destination register.
- mem_reg_write  in  1  MEM-stage write enable.
- mem_alu_out  in  XLEN  MEM-stage ALU result.
- wb_rd  in  RAW  WB-stage destination register.
- wb_reg_write  in  1  WB-stage write enable.
- wb_data  in  XLEN  WB-stage write data.
- mc_done  in  1  multi-cycle unit finished.
- fwd_a, fwd_b  out  XLEN  forwarded EX operands.
- pc_stall, if_id_stall  out  1  hold PC and IF/ID.
- id_ex_bubble  out  1  load NOP into ID/EX.
- if_id_flush  out  1  load NOP into IF/ID.
- mc_go  out  1  one-cycle launch pulse.
- mc_abort  out  1  one-cycle cancel pulse.
- stall_cnt, flush_cnt  out  CNT_W  performance counters.

Function
REQ-003 fwd_a SHALL be, in priority order: mem_alu_out if mem_reg_write and mem_rd!=0 and mem_rd==ex_rs1; else wb_data if wb_reg_write and wb_rd!=0 and wb_rd==ex_rs1; else ex_rd1. fwd_b SHALL follow the same rules using ex_rs2 and ex_rd2.
REQ-004 Forwarding SHALL be combinational with zero latency and SHALL never forward register 0.
REQ-005 A load-use hazard is ex_mem_read & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)); on a load-use hazard in RUN, pc_stall, if_id_stall and id_ex_bubble SHALL assert for exactly that cycle.
REQ-006 The FSM SHALL have three states: RUN, FLUSH and MC_WAIT; the state and a 2-bit flush down-counter SHALL be registered.
REQ-007 RUN to FLUSH: when ex_branch_taken, if_id_flush and id_ex_bubble SHALL assert that cycle and the counter SHALL load FLUSH_CYCLES-1; if that value is 0, the FSM SHALL stay in RUN.
REQ-008 In FLUSH, if_id_flush and id_ex_bubble SHALL assert each cycle; the FSM SHALL return to RUN when the counter reaches 0.
REQ-009 RUN to MC_WAIT: when id_mc_start, with no load-use hazard and no ex_branch_taken, mc_go SHALL pulse for 1 cycle.
REQ-010 In MC_WAIT, pc_stall, if_id_stall and id_ex_bubble SHALL assert until the cycle in which mc_done is sampled high; in that cycle the stalls SHALL deassert and the FSM SHALL go to RUN.
REQ-011 mc_done outside MC_WAIT SHALL be ignored.
REQ-012 Priority SHALL be: ex_branch_taken > load-use hazard > id_mc_start.
REQ-013 ex_branch_taken while in MC_WAIT SHALL pulse mc_abort, enter the flush sequence, and discard mc_done arriving in the same cycle.
REQ-014 ex_branch_taken while in FLUSH SHALL reload the counter (restart the flush).
REQ-015 stall_cnt SHALL increment on every cycle with pc_stall=1; flush_cnt SHALL increment once per accepted ex_branch_taken. Both SHALL saturate at all-ones and never wrap.

Reset
REQ-016 On rst, without waiting for clk, the block SHALL set: state=RUN, flush counter=0, stall_cnt=0, flush_cnt=0, mc_go=0, mc_abort=0.
REQ-017 While rst is asserted, all stall, flush and bubble outputs SHALL be 0.
REQ-018 Reset during MC_WAIT or FLUSH SHALL abandon the operation with no mc_abort pulse.

Structure
REQ-019 The state enumeration, NOP encoding 32'h00000013 and register-0 index SHALL live in shared package pipe_pkg.
REQ-020 The forwarding comparator SHALL be one sub-module, fwd_mux, instantiated once per operand.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- mem_rd=ex_rs1=5, mem_reg_write=1, mem_alu_out=0xA; wb_rd=5, wb_reg_write=1, wb_data=0xB -> fwd_a=0xA.
- ex_mem_read=1, ex_rd=3, id_rs2=3, id_use_rs2=1 -> stall and bubble for 1 cycle; stall_cnt=1.
- FLUSH_CYCLES=2, ex_branch_taken for 1 cycle -> if_id_flush high for 2 cycles; flush_cnt=1.
- id_mc_start, mc_done 4 cycles later -> mc_go pulse, then 4 stall cycles; stall_cnt=4.
- ex_branch_taken during MC_WAIT -> mc_abort pulse, flush sequence, stalls released.
- rst mid-FLUSH -> all outputs 0 immediately; counters 0; RUN on release.
- ex_rd=0, ex_mem_read=1, id_rs1=0 -> no stall.

Source files
------------

// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared types and constants for the pipeline hazard controller:
//               controller state encoding, NOP instruction word and the
//               hard-wired zero register index.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    // Hazard controller states
    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_FLUSH   = 2'd1,
        ST_MC_WAIT = 2'd2
    } state_t;

    // Canonical NOP (addi x0, x0, 0) injected by flush/bubble logic downstream
    localparam logic [31:0] c_nop = 32'h0000_0013;

    // Register x0 is hard-wired to zero and is never a forwarding source
    localparam int unsigned c_reg_zero = 0;

endpackage
`default_nettype wire

// File: rtl/fwd_mux.sv
`default_nettype none
// ============================================================================
// Module      : fwd_mux
// Description : Single-operand forwarding selector. Picks the MEM-stage ALU
//               result, then the WB-stage write data, then the register-file
//               value. Register x0 is never forwarded.
// Revision    : 1.0 - initial release
// ============================================================================
module fwd_mux
    import pipe_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int RAW  = 5
) (
    input  logic [RAW-1:0]  rs,
    input  logic [XLEN-1:0] rf_data,
    input  logic [RAW-1:0]  mem_rd,
    input  logic            mem_reg_write,
    input  logic [XLEN-1:0] mem_alu_out,
    input  logic [RAW-1:0]  wb_rd,
    input  logic            wb_reg_write,
    input  logic [XLEN-1:0] wb_data,
    output logic [XLEN-1:0] fwd_out
);

    localparam logic [RAW-1:0] c_r0 = RAW'(c_reg_zero);

    logic w_hit_mem;
    logic w_hit_wb;

    assign w_hit_mem = mem_reg_write && (mem_rd != c_r0) && (mem_rd == rs);
    assign w_hit_wb  = wb_reg_write  && (wb_rd  != c_r0) && (wb_rd  == rs);

    // Youngest producer wins: MEM result is newer than WB data
    always_comb begin
        fwd_out = rf_data;
        if (w_hit_mem) begin
            fwd_out = mem_alu_out;
        end else if (w_hit_wb) begin
            fwd_out = wb_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl
// Description : Five-stage pipeline hazard controller. Provides zero-latency
//               operand forwarding, load-use stall insertion, taken-branch
//               flush sequencing, multi-cycle unit launch/wait/abort control
//               and saturating stall/flush performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int RAW          = 5,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [RAW-1:0]   id_rs1,
    input  logic [RAW-1:0]   id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             id_mc_start,
    input  logic [RAW-1:0]   ex_rs1,
    input  logic [RAW-1:0]   ex_rs2,
    input  logic [RAW-1:0]   ex_rd,
    input  logic             ex_reg_write,
    input  logic             ex_mem_read,
    input  logic [XLEN-1:0]  ex_rd1,
    input  logic [XLEN-1:0]  ex_rd2,
    input  logic             ex_branch_taken,
    input  logic [RAW-1:0]   mem_rd,
    input  logic             mem_reg_write,
    input  logic [XLEN-1:0]  mem_alu_out,
    input  logic [RAW-1:0]   wb_rd,
    input  logic             wb_reg_write,
    input  logic [XLEN-1:0]  wb_data,
    input  logic             mc_done,
    output logic [XLEN-1:0]  fwd_a,
    output logic [XLEN-1:0]  fwd_b,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             id_ex_bubble,
    output logic             if_id_flush,
    output logic             mc_go,
    output logic             mc_abort,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    // Flush length is clamped to the 1..3 range the 2-bit counter supports
    localparam int          c_flush_len  = (FLUSH_CYCLES < 1) ? 1 :
                                           (FLUSH_CYCLES > 3) ? 3 : FLUSH_CYCLES;
    localparam logic [1:0]  c_flush_load = 2'(c_flush_len - 1);
    localparam logic [RAW-1:0] c_r0      = RAW'(c_reg_zero);

    // A load's write enable is implied by ex_mem_read; this input is
    // deliberately not part of the hazard equation.
    logic w_unused_ok;
    assign w_unused_ok = ex_reg_write;

    // ------------------------------------------------------------------
    // Forwarding
    // ------------------------------------------------------------------
    fwd_mux #(.XLEN(XLEN), .RAW(RAW)) u_fwd_a (
        .rs            (ex_rs1),
        .rf_data       (ex_rd1),
        .mem_rd        (mem_rd),
        .mem_reg_write (mem_reg_write),
        .mem_alu_out   (mem_alu_out),
        .wb_rd         (wb_rd),
        .wb_reg_write  (wb_reg_write),
        .wb_data       (wb_data),
        .fwd_out       (fwd_a)
    );

    fwd_mux #(.XLEN(XLEN), .RAW(RAW)) u_fwd_b (
        .rs            (ex_rs2),
        .rf_data       (ex_rd2),
        .mem_rd        (mem_rd),
        .mem_reg_write (mem_reg_write),
        .mem_alu_out   (mem_alu_out),
        .wb_rd         (wb_rd),
        .wb_reg_write  (wb_reg_write),
        .wb_data       (wb_data),
        .fwd_out       (fwd_b)
    );

    // ------------------------------------------------------------------
    // Hazard control FSM
    // ------------------------------------------------------------------
    state_t           state_q, state_d;
    logic [1:0]       cnt_q, cnt_d;
    logic             mc_go_q, mc_go_d;
    logic             mc_abort_q, mc_abort_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic w_load_use;
    logic w_stall;
    logic w_bubble;
    logic w_flush;
    logic w_br_accept;

    assign w_load_use = ex_mem_read && (ex_rd != c_r0) &&
                        ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                         (id_use_rs2 && (id_rs2 == ex_rd)));

    // Next-state and control decode; a taken branch always wins
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mc_go_d     = 1'b0;
        mc_abort_d  = 1'b0;
        w_stall     = 1'b0;
        w_bubble    = 1'b0;
        w_flush     = 1'b0;
        w_br_accept = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (ex_branch_taken) begin
                    w_flush     = 1'b1;
                    w_bubble    = 1'b1;
                    w_br_accept = 1'b1;
                end else if (w_load_use) begin
                    w_stall  = 1'b1;
                    w_bubble = 1'b1;
                end else if (id_mc_start) begin
                    mc_go_d = 1'b1;
                    state_d = ST_MC_WAIT;
                end
            end

            ST_FLUSH: begin
                w_flush  = 1'b1;
                w_bubble = 1'b1;
                if (ex_branch_taken) begin
                    w_br_accept = 1'b1;
                end else if (cnt_q <= 2'd1) begin
                    cnt_d   = 2'd0;
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end

            ST_MC_WAIT: begin
                if (ex_branch_taken) begin
                    // Cancel the unit; any coincident mc_done is dropped
                    mc_abort_d  = 1'b1;
                    w_flush     = 1'b1;
                    w_bubble    = 1'b1;
                    w_br_accept = 1'b1;
                end else if (mc_done) begin
                    state_d = ST_RUN;
                end else begin
                    w_stall  = 1'b1;
                    w_bubble = 1'b1;
                end
            end

            default: begin
                state_d = ST_RUN;
                cnt_d   = 2'd0;
            end
        endcase

        // Every accepted branch (re)starts the flush sequence
        if (w_br_accept) begin
            cnt_d   = c_flush_load;
            state_d = (c_flush_load != 2'd0) ? ST_FLUSH : ST_RUN;
        end
    end

    // Saturating performance counters
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (w_stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (w_br_accept && (flush_cnt_q != {CNT_W{1'b1}})) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    // State, flush counter, pulses and counters; reset abandons any operation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RUN;
            cnt_q       <= 2'd0;
            mc_go_q     <= 1'b0;
            mc_abort_q  <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mc_go_q     <= mc_go_d;
            mc_abort_q  <= mc_abort_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Pipeline controls are forced low while reset is held
    assign pc_stall     = w_stall  & ~rst;
    assign if_id_stall  = w_stall  & ~rst;
    assign id_ex_bubble = w_bubble & ~rst;
    assign if_id_flush  = w_flush  & ~rst;
    assign mc_go        = mc_go_q;
    assign mc_abort     = mc_abort_q;
    assign stall_cnt    = stall_cnt_q;
    assign flush_cnt    = flush_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_hazard_ctrl
// Description : Directed scoreboard bench for pipe_hazard_ctrl
//               (FLUSH_CYCLES = 2). Stimulus pushes hand-computed expected
//               outputs per cycle; a monitor pops and compares each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    localparam int XLEN = 32;
    localparam int RAW  = 5;
    localparam int CW   = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [RAW-1:0]  id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic            id_use_rs1, id_use_rs2, id_mc_start;
    logic            ex_reg_write, ex_mem_read, ex_branch_taken;
    logic            mem_reg_write, wb_reg_write, mc_done;
    logic [XLEN-1:0] ex_rd1, ex_rd2, mem_alu_out, wb_data;
    logic [XLEN-1:0] fwd_a, fwd_b;
    logic            pc_stall, if_id_stall, id_ex_bubble, if_id_flush;
    logic            mc_go, mc_abort;
    logic [CW-1:0]   stall_cnt, flush_cnt;

    pipe_hazard_ctrl #(.XLEN(XLEN), .RAW(RAW), .FLUSH_CYCLES(2), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_mc_start(id_mc_start),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_rd1(ex_rd1), .ex_rd2(ex_rd2),
        .ex_branch_taken(ex_branch_taken),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_alu_out(mem_alu_out),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_data(wb_data),
        .mc_done(mc_done),
        .fwd_a(fwd_a), .fwd_b(fwd_b),
        .pc_stall(pc_stall), .if_id_stall(if_id_stall),
        .id_ex_bubble(id_ex_bubble), .if_id_flush(if_id_flush),
        .mc_go(mc_go), .mc_abort(mc_abort),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] c_rd1 = 32'h0000_1111;
    localparam logic [31:0] c_rd2 = 32'h0000_2222;
    localparam logic [31:0] c_mem = 32'h0000_000A;
    localparam logic [31:0] c_wb  = 32'h0000_000B;

    typedef struct {
        string       name;
        logic [31:0] fa;
        logic [31:0] fb;
        bit          st;
        bit          bb;
        bit          fl;
        bit          go;
        bit          ab;
        int          sc;
        int          fc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_x;
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic chk(input string nm, input string fld, input logic [31:0] act,
                       input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s.%s: got %h expected %h", nm, fld, act, req);
        end
    endtask

    task automatic sb_push(input string n, input logic [31:0] fa, input logic [31:0] fb,
                           input bit st, input bit bb, input bit fl, input bit go,
                           input bit ab, input int sc, input int fc);
        exp_t e;
        e.name = n; e.fa = fa; e.fb = fb; e.st = st; e.bb = bb; e.fl = fl;
        e.go = go; e.ab = ab; e.sc = sc; e.fc = fc;
        sb.push_back(e);
    endtask

    task automatic idle();
        id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        id_mc_start = 1'b0;
        ex_rs1 = '0; ex_rs2 = '0; ex_rd = '0;
        ex_reg_write = 1'b0; ex_mem_read = 1'b0; ex_branch_taken = 1'b0;
        ex_rd1 = c_rd1; ex_rd2 = c_rd2;
        mem_rd = '0; mem_reg_write = 1'b0; mem_alu_out = c_mem;
        wb_rd = '0; wb_reg_write = 1'b0; wb_data = c_wb;
        mc_done = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    // Monitor: compares one expected record per cycle, away from the clock edge
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_x = sb.pop_front();
            chk(mon_x.name, "fwd_a",        fwd_a,                 mon_x.fa);
            chk(mon_x.name, "fwd_b",        fwd_b,                 mon_x.fb);
            chk(mon_x.name, "pc_stall",     {31'd0, pc_stall},     {31'd0, mon_x.st});
            chk(mon_x.name, "if_id_stall",  {31'd0, if_id_stall},  {31'd0, mon_x.st});
            chk(mon_x.name, "id_ex_bubble", {31'd0, id_ex_bubble}, {31'd0, mon_x.bb});
            chk(mon_x.name, "if_id_flush",  {31'd0, if_id_flush},  {31'd0, mon_x.fl});
            chk(mon_x.name, "mc_go",        {31'd0, mc_go},        {31'd0, mon_x.go});
            chk(mon_x.name, "mc_abort",     {31'd0, mc_abort},     {31'd0, mon_x.ab});
            chk(mon_x.name, "stall_cnt",    {16'd0, stall_cnt},    32'(mon_x.sc));
            chk(mon_x.name, "flush_cnt",    {16'd0, flush_cnt},    32'(mon_x.fc));
        end
    end

    initial begin
        idle();
        // Reset held
        step(); sb_push("reset", c_rd1, c_rd2, 0,0,0,0,0, 0,0);
        step(); rst = 1'b0; sb_push("post_rst", c_rd1, c_rd2, 0,0,0,0,0, 0,0);

        // Forwarding
        step(); ex_rs1 = 5; ex_rs2 = 9; mem_rd = 5; mem_reg_write = 1; wb_rd = 5; wb_reg_write = 1;
        sb_push("fwd_mem_over_wb", c_mem, c_rd2, 0,0,0,0,0, 0,0);
        step(); ex_rs1 = 5; ex_rs2 = 5; mem_rd = 5; wb_rd = 5; wb_reg_write = 1;
        sb_push("fwd_wb", c_wb, c_wb, 0,0,0,0,0, 0,0);
        step(); mem_reg_write = 1; wb_reg_write = 1;
        sb_push("fwd_r0", c_rd1, c_rd2, 0,0,0,0,0, 0,0);
        step(); ex_rs1 = 5; ex_rs2 = 6; mem_rd = 6; mem_reg_write = 1; wb_rd = 5; wb_reg_write = 1;
        sb_push("fwd_split", c_wb, c_mem, 0,0,0,0,0, 0,0);

        // Load-use
        step(); ex_mem_read = 1; ex_rd = 3; id_rs2 = 3; id_use_rs2 = 1;
        sb_push("load_use", c_rd1, c_rd2, 1,1,0,0,0, 0,0);
        step(); sb_push("load_use_rel", c_rd1, c_rd2, 0,0,0,0,0, 1,0);
        step(); ex_mem_read = 1; ex_rd = 3; id_rs2 = 3;
        sb_push("lu_src_unused", c_rd1, c_rd2, 0,0,0,0,0, 1,0);
        step(); ex_mem_read = 1; id_use_rs1 = 1;
        sb_push("lu_r0", c_rd1, c_rd2, 0,0,0,0,0, 1,0);
        step(); mc_done = 1;
        sb_push("mc_done_in_run", c_rd1, c_rd2, 0,0,0,0,0, 1,0);

        // Taken branch, two-cycle flush
        step(); ex_branch_taken = 1;
        sb_push("br_flush0", c_rd1, c_rd2, 0,1,1,0,0, 1,0);
        step(); sb_push("br_flush1", c_rd1, c_rd2, 0,1,1,0,0, 1,1);
        step(); sb_push("br_done", c_rd1, c_rd2, 0,0,0,0,0, 1,1);

        // Multi-cycle op with four wait cycles
        step(); id_mc_start = 1;
        sb_push("mc_start", c_rd1, c_rd2, 0,0,0,0,0, 1,1);
        for (int i = 0; i < 4; i++) begin
            step(); sb_push("mc_wait", c_rd1, c_rd2, 1,1,0, (i == 0), 0, 1 + i, 1);
        end
        step(); mc_done = 1;
        sb_push("mc_done", c_rd1, c_rd2, 0,0,0,0,0, 5,1);
        step(); sb_push("mc_after", c_rd1, c_rd2, 0,0,0,0,0, 5,1);

        // Load-use beats multi-cycle start
        step(); ex_mem_read = 1; ex_rd = 4; id_rs1 = 4; id_use_rs1 = 1; id_mc_start = 1;
        sb_push("lu_over_mc", c_rd1, c_rd2, 1,1,0,0,0, 5,1);
        step(); sb_push("no_mc_go", c_rd1, c_rd2, 0,0,0,0,0, 6,1);

        // Branch during MC_WAIT with coincident mc_done
        step(); id_mc_start = 1;
        sb_push("mc_start2", c_rd1, c_rd2, 0,0,0,0,0, 6,1);
        step(); sb_push("mc_wait2a", c_rd1, c_rd2, 1,1,0,1,0, 6,1);
        step(); sb_push("mc_wait2b", c_rd1, c_rd2, 1,1,0,0,0, 7,1);
        step(); ex_branch_taken = 1; mc_done = 1;
        sb_push("br_in_mc", c_rd1, c_rd2, 0,1,1,0,0, 8,1);
        step(); sb_push("abort_pulse", c_rd1, c_rd2, 0,1,1,0,1, 8,2);
        step(); sb_push("abort_done", c_rd1, c_rd2, 0,0,0,0,0, 8,2);

        // Branch inside FLUSH restarts the sequence
        step(); ex_branch_taken = 1;
        sb_push("rs_0", c_rd1, c_rd2, 0,1,1,0,0, 8,2);
        step(); ex_branch_taken = 1;
        sb_push("rs_1", c_rd1, c_rd2, 0,1,1,0,0, 8,3);
        step(); sb_push("rs_2", c_rd1, c_rd2, 0,1,1,0,0, 8,4);
        step(); sb_push("rs_end", c_rd1, c_rd2, 0,0,0,0,0, 8,4);

        // Asynchronous reset in the middle of FLUSH, with a hazard present
        step(); ex_branch_taken = 1;
        sb_push("rf_br", c_rd1, c_rd2, 0,1,1,0,0, 8,4);
        step(); rst = 1'b1; ex_mem_read = 1; ex_rd = 3; id_rs1 = 3; id_use_rs1 = 1;
        sb_push("rst_mid_flush", c_rd1, c_rd2, 0,0,0,0,0, 0,0);
        step(); rst = 1'b0;
        sb_push("rst_release", c_rd1, c_rd2, 0,0,0,0,0, 0,0);
        step(); ex_mem_read = 1; ex_rd = 3; id_rs1 = 3; id_use_rs1 = 1;
        sb_push("run_after_rst", c_rd1, c_rd2, 1,1,0,0,0, 0,0);
        step(); sb_push("final", c_rd1, c_rd2, 0,0,0,0,0, 1,0);

        // Drain the scoreboard within a bounded number of cycles
        repeat (3) @(posedge clk);
        n_cmp++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
